mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/rv32ima_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 40 ++++
 rtl/mem_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rv32ima_pkg.sv
// Shared types for the rv32ima memory side: word type, load/store width encoding
// and the responder FSM states.
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  localparam int LDST_WIDTH_W = 2;

  typedef enum logic [LDST_WIDTH_W-1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } ldst_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DREQ = 2'd1,
    IREQ = 2'd2,
    RESP = 2'd3
  } mem_resp_state_t;

  // Unused encoding 2'b11 is treated like WORD everywhere.
  function automatic logic is_misaligned(input logic [LDST_WIDTH_W-1:0] width,
                                         input logic [1:0] off);
    case (width)
      BYTE:    is_misaligned = 1'b0;
      HALF:    is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables and lane replication for stores, and
// right-alignment with zero extension for loads.
module mem_lane_align
  import rv32ima_pkg::*;
(
  input  logic [LDST_WIDTH_W-1:0] width,
  input  logic [1:0]              off,
  input  word_t                   store,
  input  word_t                   rdata,
  output logic [3:0]              be,
  output word_t                   wdata,
  output word_t                   load
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(rdata >> {off, 3'b000});
  assign half_sel = 16'(rdata >> {off[1], 4'b0000});

  always_comb begin
    be    = 4'b1111;
    wdata = store;
    load  = rdata;
    case (width)
      BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{store[7:0]}};
        load  = {24'h0, byte_sel};
      end
      HALF: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wdata = {2{store[15:0]}};
        load  = {16'h0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Arbitrates CPU instruction fetches and data loads/stores onto one single-port
// RAM with variable-latency completion, returning one-cycle hit pulses.
module mem_responder
  import rv32ima_pkg::*;
#(
  parameter int RAM_AW = 14
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  word_t                   iaddr,
  input  logic                    iren,
  output word_t                   idata,
  output logic                    ihit,
  input  word_t                   daddr,
  input  logic                    dren,
  input  logic                    dwen,
  input  word_t                   dstore,
  input  logic [LDST_WIDTH_W-1:0] dwidth,
  output word_t                   dload,
  output logic                    dhit,
  output logic                    ram_req,
  output logic                    ram_we,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic [3:0]              ram_be,
  output word_t                   ram_wdata,
  input  logic                    ram_ack,
  input  word_t                   ram_rdata,
  output logic                    misalign,
  output logic [1:0]              dbg_state
);

  // RAM handshake: ram_req rises with the request fields and they all stay
  // frozen until the cycle ram_ack is sampled high; ram_rdata is only taken then.

  mem_resp_state_t         state;
  logic [LDST_WIDTH_W-1:0] width_q;
  logic [LDST_WIDTH_W-1:0] lane_width;
  logic [1:0]              off_q;
  logic [1:0]              lane_off;
  logic                    is_store_q;
  logic                    data_req;
  logic [3:0]              lane_be;
  word_t                   lane_wdata;
  word_t                   lane_load;
  logic                    unused_bits;

  assign data_req  = dren | dwen;
  assign dbg_state = state;

  // The aligner sees the live request in IDLE (store lanes) and the latched one later (load extract).
  assign lane_width = (state == IDLE) ? dwidth : width_q;
  assign lane_off   = (state == IDLE) ? daddr[1:0] : off_q;

  assign unused_bits = ^{iaddr[31:RAM_AW+2], iaddr[1:0], daddr[31:RAM_AW+2]};

  mem_lane_align u_align (
    .width (lane_width),
    .off   (lane_off),
    .store (dstore),
    .rdata (ram_rdata),
    .be    (lane_be),
    .wdata (lane_wdata),
    .load  (lane_load)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_be     <= '0;
      ram_wdata  <= '0;
      ihit       <= 1'b0;
      dhit       <= 1'b0;
      misalign   <= 1'b0;
      idata      <= '0;
      dload      <= '0;
      width_q    <= WORD;
      off_q      <= 2'b00;
      is_store_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req) begin
            width_q    <= dwidth;
            off_q      <= daddr[1:0];
            is_store_q <= dwen;
            if (is_misaligned(dwidth, daddr[1:0])) begin
              state    <= RESP;
              dhit     <= 1'b1;
              misalign <= 1'b1;
              dload    <= '0;
            end else begin
              state     <= DREQ;
              ram_req   <= 1'b1;
              ram_we    <= dwen;
              ram_addr  <= daddr[RAM_AW+1:2];
              ram_be    <= lane_be;
              ram_wdata <= dwen ? lane_wdata : '0;
            end
          end else if (iren) begin
            state     <= IREQ;
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= iaddr[RAM_AW+1:2];
            ram_be    <= 4'b1111;
            ram_wdata <= '0;
          end
        end
        DREQ: begin
          if (ram_ack) begin
            state   <= RESP;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            dhit    <= 1'b1;
            dload   <= is_store_q ? '0 : lane_load;
          end
        end
        IREQ: begin
          if (ram_ack) begin
            state   <= RESP;
            ram_req <= 1'b0;
            ihit    <= 1'b1;
            idata   <= ram_rdata;
          end
        end
        RESP: begin
          state    <= IDLE;
          ihit     <= 1'b0;
          dhit     <= 1'b0;
          misalign <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
